// File: rtl/pacman_pkg.sv
// Shared palette constants, ghost mode encoding and colour-selection helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pacman_pkg;

    localparam logic [2:0] IDX_BLACK  = 3'd0;
    localparam logic [2:0] IDX_YELLOW = 3'd1;
    localparam logic [2:0] IDX_RED    = 3'd2;
    localparam logic [2:0] IDX_WHITE  = 3'd3;
    localparam logic [2:0] IDX_BLUE   = 3'd4;
    localparam logic [2:0] IDX_PINK   = 3'd5;
    localparam logic [2:0] IDX_CYAN   = 3'd6;
    localparam logic [2:0] IDX_ORANGE = 3'd7;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FRIGHT = 2'd1,
        FLASH  = 2'd2
    } ghost_mode_t;

    // An eaten ghost is drawn in its own colour even while the others are blue.
    function automatic logic [2:0] ghost_colour(input ghost_mode_t mode,
                                                input logic        eaten,
                                                input logic        flash_ph,
                                                input logic [2:0]  own_idx);
        logic [2:0] idx;
        idx = own_idx;
        if (!eaten) begin
            if (mode == FRIGHT) begin
                idx = IDX_BLUE;
            end else if (mode == FLASH) begin
                idx = flash_ph ? IDX_WHITE : IDX_BLUE;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ghost_palette_ctrl_frame_divider.sv
// Tick-enabled modulo-N counter: pulse_o fires on the enabled tick that completes N ticks.
// Latency: pulse_o is combinational from en_i/clr_i and the registered count.
// Backpressure: none; en_i low holds the count, clr_i restarts it from zero.
module frame_divider #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic pulse_o
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_end;

    assign at_end  = (cnt_q == W'(N - 1));
    assign pulse_o = en_i & ~clr_i & at_end;

    // Count enabled ticks, wrapping to zero on the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_end ? '0 : cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ghost_palette_ctrl.sv
// Ghost palette sequencer (normal / frightened / flashing) plus power-pellet blink enable.
// Latency: outputs are registered from next-state, so they change on the edge that samples the cause.
// Backpressure: none; freeze holds all counters while energizer/ghost_eaten are still taken.
// Optional pellet blinking is built when GHOST_PALETTE_PELLET_BLINK_EN is defined.
module ghost_palette_ctrl
    import pacman_pkg::*;
#(
    parameter int FRIGHT_FRAMES = 360,
    parameter int FLASH_FRAMES  = 120,
    parameter int FLASH_PERIOD  = 12,
    parameter int BLINK_PERIOD  = 10,
    parameter int CNT_W         = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       freeze,
    input  logic       energizer,
    input  logic [2:0] ghost_eaten,
    output logic [2:0] blinky_idx,
    output logic [2:0] pinky_idx,
    output logic [2:0] inky_idx,
    output logic       fright_active,
    output logic       pellet_visible
);

    // Elaboration-time parameter sanity.
    if (FLASH_FRAMES >= FRIGHT_FRAMES) begin : g_bad_flash
        $error("FLASH_FRAMES must be smaller than FRIGHT_FRAMES");
    end
    if (FRIGHT_FRAMES >= (1 << CNT_W)) begin : g_bad_width
        $error("CNT_W too narrow for FRIGHT_FRAMES");
    end
    if (FLASH_PERIOD < 1 || BLINK_PERIOD < 1) begin : g_bad_period
        $error("FLASH_PERIOD and BLINK_PERIOD must be at least 1");
    end

    ghost_mode_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mask_q, mask_d;
    logic             flash_ph_q, flash_ph_d;
    logic             flash_clr, flash_pulse;
    logic [2:0]       blinky_q, pinky_q, inky_q;
    logic             fright_q;
    logic             tick;

    assign tick = frame_tick & ~freeze;

    // Mode/counter/eaten-mask next state; energizer overrides tick and ghost_eaten.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        if (energizer) begin
            state_d = FRIGHT;
            cnt_d   = CNT_W'(FRIGHT_FRAMES);
            mask_d  = '0;
        end else if (state_q != NORMAL) begin
            mask_d = mask_q | ghost_eaten;
            if (tick) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                // cnt<=1 rather than ==1 so a degenerate count can never strand FLASH.
                if (state_q == FRIGHT && cnt_q == CNT_W'(FLASH_FRAMES + 1)) begin
                    state_d = FLASH;
                end else if (state_q == FLASH && cnt_q <= CNT_W'(1)) begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                    mask_d  = '0;
                end
            end
        end
    end

    // The flash divider only runs while FLASH persists; any entry restarts it at phase 0.
    assign flash_clr = !(state_q == FLASH && state_d == FLASH);

    frame_divider #(
        .N (FLASH_PERIOD)
    ) u_flash_div (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (flash_clr),
        .en_i    (tick),
        .pulse_o (flash_pulse)
    );

    // Flash phase toggles on each completed half-cycle, forced blue outside FLASH.
    always_comb begin
        flash_ph_d = 1'b0;
        if (!flash_clr) begin
            flash_ph_d = flash_ph_q ^ flash_pulse;
        end
    end

    // State, counters and registered colour outputs derived from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= NORMAL;
            cnt_q      <= '0;
            mask_q     <= '0;
            flash_ph_q <= 1'b0;
            blinky_q   <= IDX_RED;
            pinky_q    <= IDX_PINK;
            inky_q     <= IDX_CYAN;
            fright_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            flash_ph_q <= flash_ph_d;
            blinky_q   <= ghost_colour(state_d, mask_d[0], flash_ph_d, IDX_RED);
            pinky_q    <= ghost_colour(state_d, mask_d[1], flash_ph_d, IDX_PINK);
            inky_q     <= ghost_colour(state_d, mask_d[2], flash_ph_d, IDX_CYAN);
            fright_q   <= (state_d != NORMAL);
        end
    end

    assign blinky_idx    = blinky_q;
    assign pinky_idx     = pinky_q;
    assign inky_idx      = inky_q;
    assign fright_active = fright_q;

`ifdef GHOST_PALETTE_PELLET_BLINK_EN
    logic blink_pulse;
    logic pellet_q;

    frame_divider #(
        .N (BLINK_PERIOD)
    ) u_blink_div (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (1'b0),
        .en_i    (tick),
        .pulse_o (blink_pulse)
    );

    // Pellet visibility starts on and flips every BLINK_PERIOD ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            pellet_q <= 1'b1;
        end else if (blink_pulse) begin
            pellet_q <= ~pellet_q;
        end
    end

    assign pellet_visible = pellet_q;
`else
    assign pellet_visible = 1'b1;
`endif

endmodule

// File: tb/tb_ghost_palette_ctrl.sv
module tb_ghost_palette_ctrl;

    localparam int FF = 20;
    localparam int FL = 8;
    localparam int FP = 2;
    localparam int BP = 3;
    localparam int CW = 9;

    logic       clk = 1'b0;
    logic       reset, frame_tick, freeze, energizer;
    logic [2:0] ghost_eaten;
    logic [2:0] blinky_idx, pinky_idx, inky_idx;
    logic       fright_active, pellet_visible;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining fright ticks, eaten ghosts, ticks since reset.
    int         m_left  = 0;
    logic [2:0] m_eaten = 3'b000;
    int         m_ticks = 0;

    ghost_palette_ctrl #(
        .FRIGHT_FRAMES (FF),
        .FLASH_FRAMES  (FL),
        .FLASH_PERIOD  (FP),
        .BLINK_PERIOD  (BP),
        .CNT_W         (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .freeze         (freeze),
        .energizer      (energizer),
        .ghost_eaten    (ghost_eaten),
        .blinky_idx     (blinky_idx),
        .pinky_idx      (pinky_idx),
        .inky_idx       (inky_idx),
        .fright_active  (fright_active),
        .pellet_visible (pellet_visible)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_idx(input int g);
        logic [2:0] own;
        own = (g == 0) ? 3'd2 : (g == 1) ? 3'd5 : 3'd6;
        if (m_left == 0 || m_eaten[g]) return own;
        if (m_left > FL) return 3'd4;
        // Ticks spent flashing so far determine which half-cycle we are in.
        return (((FL - m_left) / FP) % 2 == 1) ? 3'd3 : 3'd4;
    endfunction

    function automatic logic exp_pellet();
`ifdef GHOST_PALETTE_PELLET_BLINK_EN
        return ((m_ticks / BP) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    // One clock: apply inputs, advance the model at the edge, compare just after it.
    task automatic cyc(input logic ft, input logic fz, input logic en,
                       input logic [2:0] ge, input logic rst);
        frame_tick  = ft;
        freeze      = fz;
        energizer   = en;
        ghost_eaten = ge;
        reset       = rst;
        @(posedge clk);
        if (rst) begin
            m_left  = 0;
            m_eaten = 3'b000;
            m_ticks = 0;
        end else begin
            if (ft && !fz) m_ticks++;
            if (en) begin
                m_left  = FF;
                m_eaten = 3'b000;
            end else begin
                if (m_left > 0) m_eaten |= ge;
                if (ft && !fz && m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_eaten = 3'b000;
                end
            end
        end
        #1;
        chk("blinky_idx", 32'(blinky_idx), 32'(exp_idx(0)));
        chk("pinky_idx", 32'(pinky_idx), 32'(exp_idx(1)));
        chk("inky_idx", 32'(inky_idx), 32'(exp_idx(2)));
        chk("fright_active", 32'(fright_active), 32'(m_left > 0));
        chk("pellet_visible", 32'(pellet_visible), 32'(exp_pellet()));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        end
    endtask

    initial begin
        // Reset state.
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        chk("rst_blinky", 32'(blinky_idx), 32'd2);
        chk("rst_pinky", 32'(pinky_idx), 32'd5);
        chk("rst_inky", 32'(inky_idx), 32'd6);
        chk("rst_fright", 32'(fright_active), 32'd0);
        chk("rst_pellet", 32'(pellet_visible), 32'd1);

        // Idle play with no energizer.
        ticks(30);

        // Full fright: blue, then flashing, then back to normal.
        cyc(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
        chk("enz_blinky_blue", 32'(blinky_idx), 32'd4);
        ticks(12);
        chk("flash_start_blue", 32'(inky_idx), 32'd4);
        ticks(2);
        chk("flash_white", 32'(inky_idx), 32'd3);
        ticks(6);
        chk("fright_end_pinky", 32'(pinky_idx), 32'd5);
        chk("fright_end_active", 32'(fright_active), 32'd0);

        // Pinky eaten stays pink; a new energizer clears that.
        cyc(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b0, 3'b010, 1'b0);
        chk("eaten_pinky_own", 32'(pinky_idx), 32'd5);
        chk("eaten_blinky_blue", 32'(blinky_idx), 32'd4);
        ticks(20);
        cyc(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
        chk("re_enz_pinky_blue", 32'(pinky_idx), 32'd4);

        // Energizer during FLASH restarts a full fright.
        ticks(15);
        cyc(1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
        chk("flash_enz_blinky", 32'(blinky_idx), 32'd4);
        ticks(19);
        chk("refright_still_on", 32'(fright_active), 32'd1);
        ticks(1);
        chk("refright_over", 32'(fright_active), 32'd0);

        // Freeze holds the counters while ghost_eaten still registers.
        cyc(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
        ticks(3);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, (i == 4) ? 3'b001 : 3'b000, 1'b0);
        end
        chk("frozen_eaten_blinky", 32'(blinky_idx), 32'd2);
        chk("frozen_pinky_blue", 32'(pinky_idx), 32'd4);

        // Reset during FLASH with energizer high.
        ticks(12);
        cyc(1'b0, 1'b0, 1'b1, 3'b000, 1'b1);
        chk("rst_flash_inky", 32'(inky_idx), 32'd6);
        chk("rst_flash_fright", 32'(fright_active), 32'd0);
        chk("rst_flash_pellet", 32'(pellet_visible), 32'd1);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 1) == 1),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                ($urandom_range(0, 799) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghost_palette_ctrl.md
Name: ghost_palette_ctrl

Overview:
- Frame-rate controller that sets the 3-bit palette indices the ghost sprite renderers present to the colour mixer.
- Sequences normal colours, frightened (blue) mode after an energizer, and end-of-fright blue/white flashing.
- Tracks per-ghost "eaten" status so eaten ghosts revert to their own colour.
- Also generates the power-pellet blink enable for the pellet renderer.

Parameters:
- FRIGHT_FRAMES, 360: total frightened duration in frame ticks.
- FLASH_FRAMES, 120: final portion of fright spent flashing; must be < FRIGHT_FRAMES.
- FLASH_PERIOD, 12: frame ticks per flash half-cycle (blue or white).
- BLINK_PERIOD, 10: frame ticks per pellet blink half-cycle.
- CNT_W, 9: width of the fright counter; must hold FRIGHT_FRAMES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- freeze  in  1  when high, frame_tick is ignored and all counters hold
- energizer  in  1  one-cycle pulse: power pellet eaten
- ghost_eaten  in  3  one-cycle pulses [0]=blinky [1]=pinky [2]=inky
- blinky_idx  out  3  palette index for blinky
- pinky_idx  out  3  palette index for pinky
- inky_idx  out  3  palette index for inky
- fright_active  out  1  high in FRIGHT or FLASH
- pellet_visible  out  1  power-pellet draw enable

Behaviour:
- Palette indices: 2 red, 5 pink, 6 cyan, 4 blue, 3 white. Normal colours are blinky=2, pinky=5, inky=6.
- "tick" means frame_tick & ~freeze.
- States: NORMAL, FRIGHT, FLASH. Reset enters NORMAL with cnt=0, eaten_mask=0, flash_ph=0, blink_cnt=0.
- Reset values of outputs: blinky_idx=2, pinky_idx=5, inky_idx=6, fright_active=0, pellet_visible=1.
- All outputs are registered and reflect the state/counters one cycle after the causing edge.
- energizer in any state, including FRIGHT and FLASH:
  - next state FRIGHT, cnt=FRIGHT_FRAMES, eaten_mask=0, flash_ph=0.
  - Takes priority over a same-cycle tick and same-cycle ghost_eaten.
- FRIGHT:
  - Each tick decrements cnt.
  - On a tick where cnt (pre-decrement) equals FLASH_FRAMES+1, go to FLASH with flash_ph=0 and flash_cnt=FLASH_PERIOD-1.
- FLASH:
  - Each tick decrements cnt and flash_cnt.
  - When flash_cnt reaches 0 on a tick, toggle flash_ph and reload flash_cnt=FLASH_PERIOD-1.
  - On a tick where cnt=1, go to NORMAL with cnt=0 and eaten_mask=0.
- ghost_eaten[i] in FRIGHT or FLASH sets eaten_mask[i], which holds until fright ends or the next energizer. ghost_eaten is ignored in NORMAL.
- Ghost index rules:
  - NORMAL, or eaten_mask[i]=1: normal colour.
  - FRIGHT: 4.
  - FLASH: 4 when flash_ph=0, 3 when flash_ph=1.
- freeze holds every counter and the state, but energizer and ghost_eaten are still accepted while frozen.
- Counter arithmetic is unsigned CNT_W bits and never wraps. cnt is only decremented while nonzero.
- reset asserted mid-fright returns to the reset state on the next edge, regardless of other inputs.

Optional Feature:
- Macro: GHOST_PALETTE_PELLET_BLINK_EN.
- Defined:
  - blink_cnt counts ticks.
  - pellet_visible toggles every BLINK_PERIOD ticks, in all states. The first toggle comes BLINK_PERIOD ticks after reset; the first toggle drives it low.
  - freeze stops blinking.
- Undefined: no blink counter; pellet_visible is constant 1.

Decomposition:
- Shared package (pacman_pkg) holds:
  - palette index constants (IDX_BLACK=0, IDX_YELLOW=1, IDX_RED=2, IDX_WHITE=3, IDX_BLUE=4, IDX_PINK=5, IDX_CYAN=6, IDX_ORANGE=7);
  - the state enum typedef ghost_mode_t {NORMAL, FRIGHT, FLASH}.
- One natural sub-module, frame_divider: a tick-enabled modulo-N counter producing a toggle pulse, instanced for flash phase and pellet blink.

Test Plan (FRIGHT_FRAMES=20, FLASH_FRAMES=8, FLASH_PERIOD=2, BLINK_PERIOD=3):
- Release reset, 30 ticks with no energizer -> indices stay 2/5/6, fright_active=0; with the macro, pellet_visible toggles every 3 ticks starting low after tick 3.
- Energizer, then ticks -> indices 4/4/4 one cycle after the pulse. After tick 12 the state is FLASH; indices alternate 4,4,3,3,... every 2 ticks. After tick 20 indices are 2/5/6 and fright_active=0.
- Energizer, 3 ticks, ghost_eaten=3'b010 -> pinky_idx=5 while blinky/inky remain 4. After fright ends and a new energizer, pinky_idx=4 again.
- Energizer at tick 15 (in FLASH) -> returns to FRIGHT, indices 4/4/4, eaten_mask cleared, fright lasts a further 20 ticks.
- freeze=1 for 10 frame_ticks mid-FRIGHT -> cnt and indices unchanged. ghost_eaten[0] while frozen still sets blinky_idx=2.
- reset pulse during FLASH with energizer also high -> next cycle NORMAL, indices 2/5/6, pellet_visible=1.
